spi_master_cfg: RTL and testbench

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 163 ++++++++++++++++
 tb/tb_spi_master_cfg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: latches mode, bit order, divider, slave mask
// and word count on start, then streams trans_len+1 words through a tx/rx handshake.
module spi_master_cfg #(
    parameter int DW   = 8,
    parameter int NSS  = 24,
    parameter int DIVW = 8,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            lsb_first,
    input  logic [DIVW-1:0] div,
    input  logic [NSS-1:0]  ss_mask,
    input  logic [LENW-1:0] trans_len,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [DW-1:0]   tx_data,
    output logic            rx_valid,
    output logic [DW-1:0]   rx_data,
    output logic            busy,
    output logic            done,
    output logic            sclk,
    output logic            mosi,
    output logic            mosi_oe,
    input  logic            miso,
    output logic [NSS-1:0]  ss_n
);
    localparam int HW = $clog2(2 * DW);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DW - 1);
    localparam logic [HW-1:0] LAST_LEAD = HW'(2 * DW - 2);

    typedef enum logic [2:0] {IDLE, LEAD, LOAD, SHIFT, TRAIL} state_t;

    state_t          state_reg, state_next;
    logic            cpol_reg, cpha_reg, lsb_reg;
    logic [DIVW-1:0] div_reg, div_cnt_reg;
    logic [NSS-1:0]  mask_reg;
    logic [LENW-1:0] len_reg, word_cnt_reg;
    logic [HW-1:0]   half_cnt_reg;
    logic [DW-1:0]   tx_shift_reg, rx_shift_reg, rx_data_reg;
    logic            sclk_reg, mosi_reg, rx_valid_reg, done_reg;

    logic            accept, half_tick, last_half, handshake;
    logic            lead_edge, trail_edge, sample, advance, final_sample;
    logic [DW-1:0]   tx_shifted, rx_shifted;

    function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DW-1];
    endfunction

    // A start landing in the done cycle is deliberately dropped.
    assign accept     = start && (state_reg == IDLE) && !done_reg;
    assign half_tick  = (div_cnt_reg == div_reg);
    assign last_half  = (half_cnt_reg == LAST_HALF);
    assign handshake  = (state_reg == LOAD) && tx_valid;
    assign lead_edge  = (state_reg == SHIFT) && half_tick && !half_cnt_reg[0];
    assign trail_edge = (state_reg == SHIFT) && half_tick && half_cnt_reg[0];
    assign sample     = cpha_reg ? trail_edge : lead_edge;
    assign advance    = cpha_reg ? lead_edge : (trail_edge && !last_half);
    assign final_sample = sample && (cpha_reg ? last_half : (half_cnt_reg == LAST_LEAD));
    assign tx_shifted = lsb_reg ? (tx_shift_reg >> 1) : (tx_shift_reg << 1);
    assign rx_shifted = lsb_reg ? {miso, rx_shift_reg[DW-1:1]} : {rx_shift_reg[DW-2:0], miso};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = LEAD;
            LEAD:    if (half_tick) state_next = LOAD;
            LOAD:    if (tx_valid) state_next = SHIFT;
            SHIFT:   if (half_tick && last_half)
                         state_next = (word_cnt_reg == len_reg) ? TRAIL : LOAD;
            TRAIL:   if (half_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            lsb_reg      <= 1'b0;
            div_reg      <= '0;
            mask_reg     <= '0;
            len_reg      <= '0;
            div_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            half_cnt_reg <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rx_valid_reg <= final_sample;
            done_reg     <= (state_reg == TRAIL) && half_tick;

            // Divider restarts on every state change so each phase starts aligned.
            if (state_next != state_reg || half_tick)
                div_cnt_reg <= '0;
            else
                div_cnt_reg <= div_cnt_reg + DIVW'(1);

            if (accept) begin
                cpol_reg     <= cpol;
                cpha_reg     <= cpha;
                lsb_reg      <= lsb_first;
                div_reg      <= div;
                mask_reg     <= ss_mask;
                len_reg      <= trans_len;
                sclk_reg     <= cpol;
                mosi_reg     <= 1'b0;
                word_cnt_reg <= '0;
            end

            if (handshake) begin
                tx_shift_reg <= tx_data;
                half_cnt_reg <= '0;
                if (!cpha_reg)
                    mosi_reg <= first_bit(tx_data, lsb_reg);
            end else if (state_reg == SHIFT && half_tick) begin
                half_cnt_reg <= half_cnt_reg + HW'(1);
                sclk_reg     <= ~sclk_reg;
                if (last_half && word_cnt_reg != len_reg)
                    word_cnt_reg <= word_cnt_reg + LENW'(1);
            end

            if (advance) begin
                if (cpha_reg) begin
                    mosi_reg     <= first_bit(tx_shift_reg, lsb_reg);
                    tx_shift_reg <= tx_shifted;
                end else begin
                    mosi_reg     <= first_bit(tx_shifted, lsb_reg);
                    tx_shift_reg <= tx_shifted;
                end
            end

            if (sample)
                rx_shift_reg <= rx_shifted;
            if (final_sample)
                rx_data_reg <= rx_shifted;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign tx_ready = (state_reg == LOAD);
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign sclk     = sclk_reg;
    assign mosi     = busy ? mosi_reg : 1'b0;
    assign mosi_oe  = busy;

    for (genvar gi = 0; gi < NSS; gi++) begin : g_ss
        assign ss_n[gi] = busy ? ~mask_reg[gi] : 1'b1;
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: a behavioural SPI slave on ss_n[0] plus
// monitors on rx_valid/done; expected words come from hand-written tables.
module tb_spi_master_cfg;
    logic        clk = 1'b0;
    logic        rst_n, start, cpol, cpha, lsb_first;
    logic [7:0]  div, trans_len, tx_data, rx_data;
    logic [23:0] ss_mask, ss_n;
    logic        tx_valid, tx_ready, rx_valid, busy, done, sclk, mosi, mosi_oe, miso;

    int n_tests = 0;
    int n_fail  = 0;

    logic       loop_en;
    logic       s_cpol, s_cpha, s_lsb;
    logic [7:0] slv_words [8];
    logic [7:0] tx_words  [8];

    // Slave model state, only written by the monitor process
    logic       miso_s = 1'b0;
    logic [2:0] sb = 3'd0, rb = 3'd0, sw = 3'd0;
    logic [7:0] srx = 8'd0;
    logic       prev_sclk = 1'b0, prev_ss = 1'b1;
    int         lead_cnt = 0, done_cnt = 0, ss_bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] slv_rx_q[$];
    logic       first_q[$];

    int rx_b, sl_b, lead_b, done_b, ss_b, first_b, hs;

    always #5 clk = ~clk;
    assign miso = loop_en ? mosi : miso_s;

    spi_master_cfg #(.DW(8), .NSS(24), .DIVW(8), .LENW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .div(div), .ss_mask(ss_mask), .trans_len(trans_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .done(done),
        .sclk(sclk), .mosi(mosi), .mosi_oe(mosi_oe), .miso(miso), .ss_n(ss_n)
    );

    function automatic logic sbit(input logic [7:0] w, input logic [2:0] i);
        return s_lsb ? w[i] : w[3'd7 - i];
    endfunction

    wire       s_edge   = !ss_n[0] && !prev_ss && (sclk != prev_sclk);
    wire       s_lead   = (sclk != s_cpol);
    wire       s_samp   = s_edge && (s_lead ^ s_cpha);
    wire [7:0] srx_next = s_lsb ? {mosi, srx[7:1]} : {srx[6:0], mosi};

    always @(negedge clk) begin
        prev_sclk <= sclk;
        prev_ss   <= ss_n[0];
        if (rx_valid) rx_q.push_back(rx_data);
        if (done) done_cnt <= done_cnt + 1;
        if (busy && ss_n[0]) ss_bad <= ss_bad + 1;
        if (!ss_n[0] && prev_ss) begin
            sb <= 3'd0; rb <= 3'd0; sw <= 3'd0;
            miso_s <= s_cpha ? 1'b0 : sbit(slv_words[0], 3'd0);
        end
        if (s_samp) begin
            srx <= srx_next;
            rb  <= rb + 3'd1;
            if (rb == 3'd0) first_q.push_back(mosi);
            if (rb == 3'd7) slv_rx_q.push_back(srx_next);
        end
        if (s_edge && s_lead) begin
            lead_cnt <= lead_cnt + 1;
            if (s_cpha) miso_s <= sbit(slv_words[sw], sb);
        end
        if (s_edge && !s_lead) begin
            sb <= sb + 3'd1;
            if (sb == 3'd7) sw <= sw + 3'd1;
            if (!s_cpha)
                miso_s <= (sb == 3'd7) ? sbit(slv_words[sw + 3'd1], 3'd0) : sbit(slv_words[sw], sb + 3'd1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        rx_b = rx_q.size(); sl_b = slv_rx_q.size(); first_b = first_q.size();
        lead_b = lead_cnt; done_b = done_cnt; ss_b = ss_bad;
    endtask

    task automatic chk_reset();
        check("rst_ss_n", 32'(ss_n), 32'h00FF_FFFF);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_mosi_oe", 32'(mosi_oe), 32'd0);
    endtask

    // One transfer: start pulse now, feed words on tx_ready until done or abort.
    task automatic xfer(input logic pol, input logic pha, input logic lsb, input logic [7:0] dv,
                        input int nw, input int stall_idx, input int mid_start,
                        input int abort_after, output int hs_o);
        int idx, stall_n, after_n, stall_bad;
        bit fin;
        idx = 0; stall_n = 0; after_n = 0; stall_bad = 0; fin = 0; hs_o = 0;
        s_cpol = pol; s_cpha = pha; s_lsb = lsb;
        cpol = pol; cpha = pha; lsb_first = lsb; div = dv;
        ss_mask = 24'h000001; trans_len = 8'(nw - 1); tx_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (cyc == mid_start) begin
                start = 1'b1; cpol = ~pol; trans_len = 8'd5; ss_mask = 24'hFFFFFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                fin = 1;
            end else begin
                if (tx_ready && idx < nw) begin
                    if (idx == stall_idx && stall_n < 20) begin
                        tx_valid = 1'b0;
                        stall_n++;
                        if (sclk !== pol || ss_n[0] !== 1'b0) stall_bad++;
                    end else begin
                        tx_valid = 1'b1; tx_data = tx_words[idx]; idx++; hs_o++;
                    end
                end else begin
                    tx_valid = 1'b0;
                end
                if (abort_after >= 0 && hs_o >= 2) begin
                    after_n++;
                    if (after_n == abort_after) begin
                        #1 rst_n = 1'b0;
                        #1 fin = 1;
                    end
                end
                if (!fin) @(negedge clk);
            end
        end
        if (!fin) check("xfer_timeout", 32'd0, 32'd1);
        if (stall_idx >= 0) begin
            check("stall_frozen", 32'(stall_bad), 32'd0);
            check("stall_len", 32'(stall_n), 32'd20);
        end
        tx_valid = 1'b0; start = 1'b0;
        $display("[TB] xfer cpol=%0d cpha=%0d lsb=%0d div=%0d words=%0d handshakes=%0d",
                 pol, pha, lsb, dv, nw, hs_o);
    endtask

    // Called on the negedge after the done cycle.
    task automatic post(input logic pol, input int nw);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
        check("sclk_idle", 32'(sclk), 32'(pol));
        check("mosi_idle", 32'(mosi), 32'd0);
        check("mosi_oe_idle", 32'(mosi_oe), 32'd0);
        check("ss_idle", 32'(ss_n), 32'h00FF_FFFF);
        check("done_pulses", 32'(done_cnt - done_b), 32'd1);
        check("rx_pulses", 32'(rx_q.size() - rx_b), 32'(nw));
        check("ss_held", 32'(ss_bad - ss_b), 32'd0);
        check("sclk_periods", 32'(lead_cnt - lead_b), 32'(8 * nw));
        for (int i = 0; i < nw; i++) begin
            if (rx_b + i < rx_q.size())
                check("rx_word", 32'(rx_q[rx_b + i]), 32'(slv_words[i]));
            if (sl_b + i < slv_rx_q.size())
                check("tx_word", 32'(slv_rx_q[sl_b + i]), 32'(tx_words[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        div = 8'd0; ss_mask = 24'd0; trans_len = 8'd0; tx_valid = 1'b0; tx_data = 8'd0;
        loop_en = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
        for (int i = 0; i < 8; i++) begin slv_words[i] = 8'h00; tx_words[i] = 8'h00; end

        repeat (3) @(negedge clk);
        chk_reset();

        // Mode 0 loopback, start in the first cycle out of reset
        loop_en = 1'b1; tx_words[0] = 8'hA5; slv_words[0] = 8'hA5;
        snap();
        rst_n = 1'b1;
        xfer(1'b0, 1'b0, 1'b0, 8'd1, 1, -1, -1, -1, hs);
        @(negedge clk);
        post(1'b0, 1);
        check("hs_loopback", 32'(hs), 32'd1);
        loop_en = 1'b0;

        // All four modes, slave 0x3C against tx 0xC3
        for (int m = 0; m < 4; m++) begin
            tx_words[0] = 8'hC3; slv_words[0] = 8'h3C;
            snap();
            xfer(m[1], m[0], 1'b0, (m == 2) ? 8'd0 : 8'd2, 1, -1, -1, -1, hs);
            @(negedge clk);
            post(m[1], 1);
        end

        // LSB-first
        tx_words[0] = 8'h01; slv_words[0] = 8'h80;
        snap();
        xfer(1'b0, 1'b0, 1'b1, 8'd1, 1, -1, -1, -1, hs);
        @(negedge clk);
        post(1'b0, 1);
        if (first_b < first_q.size())
            check("first_mosi_bit", 32'(first_q[first_b]), 32'd1);

        // Four words with a 20-cycle underrun before word 2, div=0
        tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33; tx_words[3] = 8'h44;
        slv_words[0] = 8'hA1; slv_words[1] = 8'hB2; slv_words[2] = 8'hC3; slv_words[3] = 8'hD4;
        snap();
        xfer(1'b1, 1'b1, 1'b0, 8'd0, 4, 2, -1, -1, hs);
        @(negedge clk);
        post(1'b1, 4);
        check("hs_multi", 32'(hs), 32'd4);

        // Start while busy ignored; start in the done cycle ignored then accepted
        tx_words[0] = 8'h66; slv_words[0] = 8'h99;
        snap();
        xfer(1'b0, 1'b0, 1'b0, 8'd1, 1, -1, 10, -1, hs);
        start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        post(1'b0, 1);
        check("hs_busy_start", 32'(hs), 32'd1);
        tx_words[0] = 8'h0F; slv_words[0] = 8'hF0;
        snap();
        xfer(1'b1, 1'b0, 1'b0, 8'd1, 1, -1, -1, -1, hs);
        @(negedge clk);
        post(1'b1, 1);

        // Asynchronous reset in the middle of word 1, then a clean transfer
        tx_words[0] = 8'hE7; tx_words[1] = 8'h18; tx_words[2] = 8'h42;
        slv_words[0] = 8'h5A; slv_words[1] = 8'h5A; slv_words[2] = 8'h5A;
        xfer(1'b1, 1'b0, 1'b0, 8'd1, 3, -1, -1, 6, hs);
        chk_reset();
        repeat (2) @(negedge clk);
        tx_words[0] = 8'h5A; slv_words[0] = 8'h96;
        snap();
        rst_n = 1'b1;
        xfer(1'b0, 1'b1, 1'b0, 8'd1, 1, -1, -1, -1, hs);
        @(negedge clk);
        post(1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
